// File: rtl/sram_rd_burst.sv
// sram_rd_burst -- sequential read-burst engine in front of spram_wait.
//
// On an accepted start it reads len words from base_addr upward (address
// wraps modulo 2^aw), waits on mem_valid for every word, and streams the
// words out through a first-word-fall-through FIFO of depth 2^fd_log2.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               command strobe, ignored while busy
//   base_addr, len      burst descriptor, sampled with start (len 0 = empty)
//   busy, done          burst in flight / one-cycle completion pulse
//   mem_ce/oe/we        RAM control (we is tied low, read-only engine)
//   mem_addr_r          RAM read address, stable across ISSUE+WAIT
//   mem_data, mem_valid RAM read data and its qualifier
//   o_data, o_valid     FIFO head / FIFO not empty
//   o_ready             downstream accept
module sram_rd_burst #(
  parameter int aw      = 12,
  parameter int dw      = 16,
  parameter int lw      = 8,
  parameter int fd_log2 = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [aw-1:0] base_addr,
  input  logic [lw-1:0] len,
  output logic          busy,
  output logic          done,
  output logic          mem_ce,
  output logic          mem_oe,
  output logic          mem_we,
  output logic [aw-1:0] mem_addr_r,
  input  logic [dw-1:0] mem_data,
  input  logic          mem_valid,
  output logic [dw-1:0] o_data,
  output logic          o_valid,
  input  logic          o_ready
);

  localparam int DEPTH = 1 << fd_log2;
  localparam logic [fd_log2:0] DEPTH_C = (fd_log2+1)'(DEPTH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_STALL = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;

  logic [2:0]         r_state, w_state_nxt;
  logic [aw-1:0]      r_addr, w_addr_nxt;   // address of the next word to read
  logic [aw-1:0]      r_mem_addr;           // address presented to the RAM
  logic [lw-1:0]      r_remain;
  logic               r_done;
  logic [dw-1:0]      r_fifo [DEPTH];
  logic [fd_log2-1:0] r_wp, r_rp;
  logic [fd_log2:0]   r_cnt, w_cnt_nxt;
  logic               w_push, w_pop, w_accept, w_full;

  // done is registered, so the IDLE state already holds during the done
  // cycle; busy covers that cycle explicitly so start stays blocked.
  assign busy     = (r_state != S_IDLE) || r_done;
  assign done     = r_done;
  assign w_accept = start && !busy;

  // mem_valid is only honoured in WAIT; a stale valid during ISSUE is dropped.
  assign w_push    = (r_state == S_WAIT) && mem_valid;
  assign o_valid   = (r_cnt != '0);
  assign w_pop     = o_valid && o_ready;
  assign w_full    = (r_cnt == DEPTH_C);
  assign w_cnt_nxt = r_cnt + (fd_log2+1)'(w_push) - (fd_log2+1)'(w_pop);

  assign mem_ce     = (r_state == S_ISSUE) || (r_state == S_WAIT);
  assign mem_oe     = mem_ce;
  assign mem_we     = 1'b0;
  assign mem_addr_r = r_mem_addr;
  assign o_data     = o_valid ? r_fifo[r_rp] : '0;

  always_comb begin
    w_state_nxt = r_state;
    w_addr_nxt  = r_addr;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (len != '0) begin
            w_addr_nxt  = base_addr;
            w_state_nxt = w_full ? S_STALL : S_ISSUE;
          end else begin
            w_state_nxt = S_DRAIN;
          end
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (mem_valid) begin
          w_addr_nxt = r_addr + aw'(1);
          if (r_remain == lw'(1))        w_state_nxt = S_DRAIN;
          else if (w_cnt_nxt == DEPTH_C) w_state_nxt = S_STALL;
          else                           w_state_nxt = S_ISSUE;
        end
      end
      S_STALL: if (!w_full) w_state_nxt = S_ISSUE;
      S_DRAIN: if (w_cnt_nxt == '0) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_mem_addr <= '0;
      r_remain   <= '0;
      r_done     <= 1'b0;
      r_wp       <= '0;
      r_rp       <= '0;
      r_cnt      <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_addr  <= w_addr_nxt;
      r_done  <= (r_state == S_DRAIN) && (w_cnt_nxt == '0);
      if (w_accept)    r_remain <= len;
      else if (w_push) r_remain <= r_remain - lw'(1);
      // RAM address only moves on entry to ISSUE, keeping it stable in WAIT.
      if (w_state_nxt == S_ISSUE) r_mem_addr <= w_addr_nxt;
      if (w_push) r_wp <= r_wp + fd_log2'(1);
      if (w_pop)  r_rp <= r_rp + fd_log2'(1);
      r_cnt <= w_cnt_nxt;
    end
  end

  // FIFO storage needs no reset; o_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) r_fifo[r_wp] <= mem_data;
  end

endmodule
